// File: rtl/sgm_pkg.sv
// Shared definitions for the stereo gradient path: pixel width, image
// geometry defaults and the counter width helper.
package sgm_pkg;

    localparam int PIXEL_WIDTH_GRAD = 11;
    localparam int IMG_WIDTH_DEF    = 640;
    localparam int IMG_HEIGHT_DEF   = 480;

    // Bits needed to count 0..n-1; never less than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/grad_line_buffer_3row_if.sv
// Pixel stream in, column triple out, for the 3-row gradient line buffer.
interface grad_line_buffer_3row_if
    import sgm_pkg::*;
#(
    parameter int PIXEL_WIDTH = PIXEL_WIDTH_GRAD,
    parameter int COL_W       = cnt_width(IMG_WIDTH_DEF),
    parameter int ROW_W       = cnt_width(IMG_HEIGHT_DEF)
);
    logic                   in_valid;
    logic                   in_sof;
    logic [PIXEL_WIDTH-1:0] in_pixel;
    logic [PIXEL_WIDTH-1:0] linebuffer0;
    logic [PIXEL_WIDTH-1:0] linebuffer1;
    logic [PIXEL_WIDTH-1:0] linebuffer2;
    logic                   out_valid;
    logic [COL_W-1:0]       out_col;
    logic [ROW_W-1:0]       out_row;
    logic                   out_eol;
    logic                   out_eof;

    // Pixel source / window-stage side.
    modport master (
        output in_valid, in_sof, in_pixel,
        input  linebuffer0, linebuffer1, linebuffer2,
        input  out_valid, out_col, out_row, out_eol, out_eof
    );

    // Line buffer side.
    modport slave (
        input  in_valid, in_sof, in_pixel,
        output linebuffer0, linebuffer1, linebuffer2,
        output out_valid, out_col, out_row, out_eol, out_eof
    );
endinterface

// File: rtl/grad_line_ram.sv
// Single-port line RAM, read-first: the read data is the word held before
// any write in the same cycle. The read is taken straight off the array so
// the cascade ram1 -> ram0 can move the old word in the same cycle; the
// caller registers the read data.
module grad_line_ram
    import sgm_pkg::*;
#(
    parameter int DEPTH = IMG_WIDTH_DEF,
    parameter int WIDTH = PIXEL_WIDTH_GRAD,
    localparam int AW   = cnt_width(DEPTH)
)(
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    // Storage write; contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (we) r_mem[addr] <= wdata;
    end

    assign rdata = r_mem[addr];
endmodule

// File: rtl/grad_line_buffer_3row.sv
// Raster-to-column converter: keeps the two previous lines and emits rows
// r-2, r-1, r at the same column, one cycle after each accepted pixel.
module grad_line_buffer_3row
    import sgm_pkg::*;
#(
    parameter int PIXEL_WIDTH = PIXEL_WIDTH_GRAD,
    parameter int IMG_WIDTH   = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT  = IMG_HEIGHT_DEF
)(
    input logic                    clock,
    input logic                    rst,
    grad_line_buffer_3row_if.slave bus
);
    localparam int COL_W = cnt_width(IMG_WIDTH);
    localparam int ROW_W = cnt_width(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [ROW_W-1:0] ROW_FIRST_VALID = ROW_W'(2);

    logic [COL_W-1:0]       r_col, w_col;
    logic [ROW_W-1:0]       r_row, w_row;
    logic                   w_last_col, w_last_row, w_row_ok;
    logic [PIXEL_WIDTH-1:0] w_ram1_q, w_ram0_q;

    logic [PIXEL_WIDTH-1:0] r_lb0, r_lb1, r_lb2;
    logic                   r_valid, r_eol, r_eof;
    logic [COL_W-1:0]       r_out_col;
    logic [ROW_W-1:0]       r_out_row;

    // Effective position of the pixel on the bus: sof resyncs it to (0,0).
    always_comb begin
        w_col = r_col;
        w_row = r_row;
        if (bus.in_sof) begin
            w_col = '0;
            w_row = '0;
        end
    end

    assign w_last_col = (w_col == COL_LAST);
    assign w_last_row = (w_row == ROW_LAST);
    assign w_row_ok   = (w_row >= ROW_FIRST_VALID);

    // ram1 holds row r-1; its old word shifts into ram0 (row r-2).
    grad_line_ram #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_WIDTH)) u_ram1 (
        .clock (clock),
        .we    (bus.in_valid),
        .addr  (w_col),
        .wdata (bus.in_pixel),
        .rdata (w_ram1_q)
    );

    grad_line_ram #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_WIDTH)) u_ram0 (
        .clock (clock),
        .we    (bus.in_valid),
        .addr  (w_col),
        .wdata (w_ram1_q),
        .rdata (w_ram0_q)
    );

    // Raster position counters, advanced only by accepted pixels.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (bus.in_valid) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_row ? '0 : w_row + ROW_W'(1);
            end else begin
                r_col <= w_col + COL_W'(1);
                r_row <= w_row;
            end
        end
    end

    // Output stage: data and position hold across gaps, strobes do not.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_lb0     <= '0;
            r_lb1     <= '0;
            r_lb2     <= '0;
            r_out_col <= '0;
            r_out_row <= '0;
            r_valid   <= 1'b0;
            r_eol     <= 1'b0;
            r_eof     <= 1'b0;
        end else begin
            r_valid <= bus.in_valid && w_row_ok;
            r_eol   <= bus.in_valid && w_row_ok && w_last_col;
            r_eof   <= bus.in_valid && w_row_ok && w_last_col && w_last_row;
            if (bus.in_valid) begin
                r_lb0     <= w_ram0_q;
                r_lb1     <= w_ram1_q;
                r_lb2     <= bus.in_pixel;
                r_out_col <= w_col;
                r_out_row <= w_row;
            end
        end
    end

    assign bus.linebuffer0 = r_lb0;
    assign bus.linebuffer1 = r_lb1;
    assign bus.linebuffer2 = r_lb2;
    assign bus.out_valid   = r_valid;
    assign bus.out_col     = r_out_col;
    assign bus.out_row     = r_out_row;
    assign bus.out_eol     = r_eol;
    assign bus.out_eof     = r_eof;
endmodule

// File: tb/tb_grad_line_buffer_3row.sv
// Directed bench for grad_line_buffer_3row on an 8x4 image with a
// scoreboard of expected output triples.
module tb_grad_line_buffer_3row;
    localparam int PW = 11;
    localparam int W  = 8;
    localparam int H  = 4;
    localparam int CW = 3;
    localparam int RW = 2;

    typedef struct packed {
        logic          v;
        logic [PW-1:0] lb0;
        logic [PW-1:0] lb1;
        logic [PW-1:0] lb2;
        logic [CW-1:0] col;
        logic [RW-1:0] row;
        logic          eol;
        logic          eof;
    } exp_t;

    logic clock = 1'b0;
    logic rst   = 1'b1;
    always #5 clock = ~clock;

    grad_line_buffer_3row_if #(.PIXEL_WIDTH(PW), .COL_W(CW), .ROW_W(RW)) bus ();

    grad_line_buffer_3row #(.PIXEL_WIDTH(PW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    exp_t          q[$];
    exp_t          hold;
    int            mcol, mrow;
    logic [PW-1:0] m1 [W];
    logic [PW-1:0] m0 [W];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, predict the output, then compare after the edge.
    task automatic step(input logic v, input logic sof, input logic [PW-1:0] pix);
        exp_t e;
        int ec, er;
        e     = hold;
        e.v   = 1'b0;
        e.eol = 1'b0;
        e.eof = 1'b0;
        bus.in_valid = v;
        bus.in_sof   = sof;
        bus.in_pixel = pix;
        if (v) begin
            ec    = sof ? 0 : mcol;
            er    = sof ? 0 : mrow;
            e.lb2 = pix;
            e.lb1 = m1[ec];
            e.lb0 = m0[ec];
            e.col = CW'(ec);
            e.row = RW'(er);
            e.v   = (er >= 2);
            e.eol = e.v && (ec == W - 1);
            e.eof = e.eol && (er == H - 1);
            m0[ec] = m1[ec];
            m1[ec] = pix;
            if (ec == W - 1) begin
                mcol = 0;
                mrow = (er == H - 1) ? 0 : er + 1;
            end else begin
                mcol = ec + 1;
                mrow = er;
            end
            hold = e;
        end
        q.push_back(e);
        @(posedge clock);
        #1;
        e = q.pop_front();
        chk("out_valid", 32'(bus.out_valid), 32'(e.v));
        chk("linebuffer2", 32'(bus.linebuffer2), 32'(e.lb2));
        chk("out_col", 32'(bus.out_col), 32'(e.col));
        chk("out_row", 32'(bus.out_row), 32'(e.row));
        chk("out_eol", 32'(bus.out_eol), 32'(e.eol));
        chk("out_eof", 32'(bus.out_eof), 32'(e.eof));
        if (e.v) begin
            chk("linebuffer1", 32'(bus.linebuffer1), 32'(e.lb1));
            chk("linebuffer0", 32'(bus.linebuffer0), 32'(e.lb0));
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_lb0"}, 32'(bus.linebuffer0), 32'd0);
        chk({tag, "_lb1"}, 32'(bus.linebuffer1), 32'd0);
        chk({tag, "_lb2"}, 32'(bus.linebuffer2), 32'd0);
        chk({tag, "_col"}, 32'(bus.out_col), 32'd0);
        chk({tag, "_row"}, 32'(bus.out_row), 32'd0);
        chk({tag, "_eol"}, 32'(bus.out_eol), 32'd0);
        chk({tag, "_eof"}, 32'(bus.out_eof), 32'd0);
    endtask

    // One full frame, pixel = base + row*16 + col, optional idle cycles in row 2.
    task automatic send_frame(input int base, input bit gap_row2);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (gap_row2 && r == 2) step(1'b0, 1'b0, '0);
                step(1'b1, 1'b0, PW'(base + r * 16 + c));
                if (r == 2 && c == 0) begin
                    chk("first_valid", 32'(bus.out_valid), 32'd1);
                    chk("first_lb0", 32'(bus.linebuffer0), 32'(base));
                    chk("first_lb1", 32'(bus.linebuffer1), 32'(base + 'h10));
                    chk("first_lb2", 32'(bus.linebuffer2), 32'(base + 'h20));
                    chk("first_row", 32'(bus.out_row), 32'd2);
                end
                if (gap_row2 && r == 2 && c == 5) begin
                    chk("gap_lb0", 32'(bus.linebuffer0), 32'(base + 'h05));
                    chk("gap_lb1", 32'(bus.linebuffer1), 32'(base + 'h15));
                    chk("gap_lb2", 32'(bus.linebuffer2), 32'(base + 'h25));
                end
                if (r == H - 1 && c == W - 1) begin
                    chk("last_eol", 32'(bus.out_eol), 32'd1);
                    chk("last_eof", 32'(bus.out_eof), 32'd1);
                    chk("last_col", 32'(bus.out_col), 32'd7);
                    chk("last_row", 32'(bus.out_row), 32'd3);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nvalid;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_pixel = '0;
        hold = '0;
        mcol = 0;
        mrow = 0;
        for (int i = 0; i < W; i++) begin
            m1[i] = '0;
            m0[i] = '0;
        end

        // Reset held for three cycles, then released.
        repeat (3) @(posedge clock);
        #1;
        chk_zero("in_reset");
        @(negedge clock);
        rst = 1'b0;
        #1;
        chk_zero("after_reset");

        // Steady frame, then a frame with gaps in row 2, then a wrapped frame.
        send_frame(0, 1'b0);
        send_frame(0, 1'b1);
        send_frame('h100, 1'b0);

        // Mid-line resync at row 2, col 3.
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < W; c++) step(1'b1, 1'b0, PW'('h200 + r * 16 + c));
        for (int c = 0; c < 3; c++) step(1'b1, 1'b0, PW'('h220 + c));
        nvalid = 0;
        for (int i = 0; i < 2 * W; i++) begin
            step(1'b1, (i == 0), PW'('h300 + (i / W) * 16 + (i % W)));
            nvalid += int'(bus.out_valid);
        end
        chk("resync_quiet", 32'(nvalid), 32'd0);
        step(1'b1, 1'b0, PW'('h320));
        chk("resync_valid", 32'(bus.out_valid), 32'd1);
        chk("resync_lb0", 32'(bus.linebuffer0), 32'h300);
        chk("resync_lb1", 32'(bus.linebuffer1), 32'h310);
        chk("resync_col", 32'(bus.out_col), 32'd0);

        // Finish row 2, run row 3 to col 3, then reset while col 4 is on the bus.
        for (int c = 1; c < W; c++) step(1'b1, 1'b0, PW'('h320 + c));
        for (int c = 0; c < 4; c++) step(1'b1, 1'b0, PW'('h330 + c));
        bus.in_valid = 1'b1;
        bus.in_pixel = PW'('h334);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("async_reset");
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        rst  = 1'b0;
        hold = '0;
        mcol = 0;
        mrow = 0;
        send_frame('h400, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
